// File: rtl/tfe_defs.sv
// Shared encodings and defaults for the tile-merge move engine.
package tfe_defs;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_SHIFT = 3'd2,
      S_SPAWN = 3'd3,
      S_CHECK = 3'd4
   } state_t;

   localparam int TW_DEF = 4;
   localparam int SW_DEF = 21;

   localparam int LFSR_TAP0 = 16;
   localparam int LFSR_TAP1 = 14;
   localparam int LFSR_TAP2 = 13;
   localparam int LFSR_TAP3 = 11;

endpackage

// File: rtl/tfe_line_merge.sv
// Compact-and-merge of one line toward index 0 (the leading edge).
module tfe_line_merge #(
   parameter int N  = 4,
   parameter int TW = 4,
   parameter int SW = 21
) (
   input  logic [N*TW-1:0] line_in,
   output logic [N*TW-1:0] line_out,
   output logic [SW:0]     inc,
   output logic            changed
);

   localparam logic [TW-1:0] EMAX = '1;

   logic [(N+1)*TW-1:0] comp;
   logic [N*TW-1:0]     work;
   logic [N*TW-1:0]     res;
   logic [SW+1:0]       acc;
   logic [TW-1:0]       t;
   logic [TW-1:0]       nx;
   logic                skip;
   int                  cnt;

   always_comb begin
      work = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (line_in[i*TW +: TW] != '0)
            work = {work[(N-1)*TW-1:0], line_in[i*TW +: TW]};
      end
      comp = {{TW{1'b0}}, work};
      res  = '0;
      acc  = '0;
      skip = 1'b0;
      cnt  = 0;
      t    = '0;
      nx   = '0;
      for (int i = 0; i < N; i++) begin
         t  = comp[i*TW +: TW];
         nx = comp[(i+1)*TW +: TW];
         if (skip) begin
            skip = 1'b0;
         end else if (t != '0) begin
            if (t == nx && t != EMAX) begin
               res  = {t + 1'b1, res[N*TW-1:TW]};
               // Increments beyond the score range just pin at 2^SW.
               if (int'(t) + 1 <= SW)
                  acc = acc + ((SW+2)'(1) << (int'(t) + 1));
               else
                  acc = acc + ((SW+2)'(1) << SW);
               skip = 1'b1;
            end else begin
               res = {t, res[N*TW-1:TW]};
            end
            cnt = cnt + 1;
         end
      end
      line_out = res >> ((N - cnt) * TW);
      if (acc > ((SW+2)'(1) << SW))
         acc = (SW+2)'(1) << SW;
      inc     = acc[SW:0];
      changed = (line_out != line_in);
   end

endmodule

// File: rtl/tfe_move_engine.sv
// Board-level move engine: per-line shift/merge, random tile spawn, game-over check.
module tfe_move_engine
   import tfe_defs::*;
#(
   parameter int          N    = 4,
   parameter int          TW   = TW_DEF,
   parameter int          SW   = SW_DEF,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        dir,
   input  logic              dir_valid,
   output logic              dir_ready,
   input  logic              load_valid,
   input  logic [N*N*TW-1:0] load_board,
   output logic [N*N*TW-1:0] board,
   output logic [SW-1:0]     score,
   output logic              busy,
   output logic              moved,
   output logic              game_over
);

   localparam int NN = N * N;
   localparam int BW = NN * TW;
   localparam int CW = $clog2(NN);
   localparam int LW = $clog2(N);
   localparam logic [TW-1:0] EMAX = '1;

   state_t          state;
   logic [BW-1:0]   board_q;
   logic [15:0]     lfsr;
   logic            lfb;
   logic [3:0]      dq;
   logic [LW-1:0]   li;
   logic            chg;
   logic            first;
   logic            nspawn;
   logic [CW-1:0]   idx;
   logic [CW-1:0]   probe;
   logic [TW-1:0]   sval;
   logic [N*TW-1:0] lin;
   logic [N*TW-1:0] lout;
   logic [SW:0]     linc;
   logic            lchg;
   logic [SW+1:0]   ssum;
   logic            any_empty;
   logic            any_pair;

   // Line position j counts from the leading edge of the move.
   function automatic int cell_of(input logic [3:0] d, input int l,
                                  input int j);
      int r;
      int c;
      r = l;
      c = j;
      unique case (1'b1)
         d[0]:    begin r = j;         c = l; end
         d[1]:    begin r = N - 1 - j; c = l; end
         d[2]:    ;
         d[3]:    c = N - 1 - j;
         default: ;
      endcase
      return r * N + c;
   endfunction

   assign board     = board_q;
   assign dir_ready = (state == S_IDLE) && !game_over;
   assign busy      = (state != S_IDLE);

   assign lfb  = lfsr[LFSR_TAP0-1] ^ lfsr[LFSR_TAP1-1]
               ^ lfsr[LFSR_TAP2-1] ^ lfsr[LFSR_TAP3-1];
   assign sval = (lfsr[3:0] == 4'd0) ? TW'(2) : TW'(1);
   assign probe = first ? CW'(int'(lfsr) % NN) : idx;
   assign ssum = {2'b00, score} + {1'b0, linc};

   always_comb begin
      lin = '0;
      for (int j = 0; j < N; j++)
         lin[j*TW +: TW] = board_q[cell_of(dq, int'(li), j)*TW +: TW];
   end

   tfe_line_merge #(
      .N  (N),
      .TW (TW),
      .SW (SW)
   ) u_merge (
      .line_in  (lin),
      .line_out (lout),
      .inc      (linc),
      .changed  (lchg)
   );

   always_comb begin
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (int i = 0; i < NN; i++)
         if (board_q[i*TW +: TW] == '0) any_empty = 1'b1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N - 1; c++)
            if (board_q[(r*N+c)*TW +: TW] == board_q[(r*N+c+1)*TW +: TW]
                && board_q[(r*N+c)*TW +: TW] != EMAX)
               any_pair = 1'b1;
      for (int r = 0; r < N - 1; r++)
         for (int c = 0; c < N; c++)
            if (board_q[(r*N+c)*TW +: TW] == board_q[((r+1)*N+c)*TW +: TW]
                && board_q[(r*N+c)*TW +: TW] != EMAX)
               any_pair = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         board_q   <= '0;
         score     <= '0;
         game_over <= 1'b0;
         moved     <= 1'b0;
         lfsr      <= SEED;
         dq        <= '0;
         li        <= '0;
         chg       <= 1'b0;
         first     <= 1'b1;
         nspawn    <= 1'b0;
         idx       <= '0;
      end else begin
         lfsr  <= {lfsr[14:0], lfb};
         moved <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (load_valid) begin
                  board_q   <= load_board;
                  score     <= '0;
                  game_over <= 1'b0;
                  state     <= S_CHECK;
               end else if (dir_valid && dir_ready && $onehot(dir)) begin
                  dq    <= dir;
                  li    <= '0;
                  chg   <= 1'b0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               for (int j = 0; j < N; j++)
                  board_q[cell_of(dq, int'(li), j)*TW +: TW] <= lout[j*TW +: TW];
               if (|ssum[SW+1:SW])
                  score <= '1;
               else
                  score <= ssum[SW-1:0];
               chg <= chg | lchg;
               if (li == LW'(N - 1)) begin
                  if (chg | lchg) begin
                     moved <= 1'b1;
                     first <= 1'b1;
                     state <= S_SPAWN;
                  end else begin
                     state <= S_CHECK;
                  end
               end else begin
                  li <= li + 1'b1;
               end
            end
            S_INIT, S_SPAWN: begin
               // Linear probe from a random start until an empty cell is hit.
               if (board_q[probe*TW +: TW] == '0) begin
                  board_q[probe*TW +: TW] <= sval;
                  first <= 1'b1;
                  if (state == S_SPAWN)
                     state <= S_CHECK;
                  else if (nspawn)
                     state <= S_IDLE;
                  else
                     nspawn <= 1'b1;
               end else begin
                  idx   <= CW'((int'(probe) + 1) % NN);
                  first <= 1'b0;
               end
            end
            S_CHECK: begin
               if (!any_empty && !any_pair)
                  game_over <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_tfe_move_engine.sv
// Directed bench for tfe_move_engine with a queue-based reference model.
module tb_tfe_move_engine;
   import tfe_defs::*;

   localparam int N  = 4;
   localparam int TW = 4;
   localparam int SW = 21;
   localparam int NN = N * N;
   localparam int BW = NN * TW;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    dir = '0;
   logic          dir_valid = 1'b0;
   logic          dir_ready;
   logic          load_valid = 1'b0;
   logic [BW-1:0] load_board = '0;
   logic [BW-1:0] board;
   logic [SW-1:0] score;
   logic          busy;
   logic          moved;
   logic          game_over;

   int            checks = 0;
   int            errors = 0;
   int            moved_cnt = 0;
   bit            mon_en = 1'b0;
   logic [BW-1:0] exp_board = '0;
   int            exp_score = 0;
   bit            exp_go = 1'b0;
   bit            exp_spawn = 1'b0;

   tfe_move_engine #(
      .N    (N),
      .TW   (TW),
      .SW   (SW),
      .SEED (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dir        (dir),
      .dir_valid  (dir_valid),
      .dir_ready  (dir_ready),
      .load_valid (load_valid),
      .load_board (load_board),
      .board      (board),
      .score      (score),
      .busy       (busy),
      .moved      (moved),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] mkb(input int v[16]);
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < NN; i++) b[i*TW +: TW] = TW'(v[i]);
      return b;
   endfunction

   function automatic int get(input logic [BW-1:0] b, input int r, input int c);
      return int'(b[(r*N+c)*TW +: TW]);
   endfunction

   // Geometric walk of line l from the edge the tiles slide toward.
   function automatic void pos(input logic [3:0] d, input int l, input int j,
                               output int r, output int c);
      r = l; c = j;
      if (d == DIR_UP)    begin r = j;         c = l; end
      if (d == DIR_DOWN)  begin r = N - 1 - j; c = l; end
      if (d == DIR_RIGHT) begin r = l;         c = N - 1 - j; end
   endfunction

   function automatic void model_move(input logic [BW-1:0] b, input logic [3:0] d,
                                      output logic [BW-1:0] o, output int inc,
                                      output bit chg);
      int q[$];
      int m[$];
      int r, c, a, v;
      o = b; inc = 0;
      for (int l = 0; l < N; l++) begin
         q.delete(); m.delete();
         for (int j = 0; j < N; j++) begin
            pos(d, l, j, r, c);
            if (get(b, r, c) != 0) q.push_back(get(b, r, c));
         end
         while (q.size() > 0) begin
            a = q.pop_front();
            if (q.size() > 0 && q[0] == a && a != 15) begin
               void'(q.pop_front());
               m.push_back(a + 1);
               inc = inc + (1 << (a + 1));
            end else begin
               m.push_back(a);
            end
         end
         for (int j = 0; j < N; j++) begin
            pos(d, l, j, r, c);
            v = (j < m.size()) ? m[j] : 0;
            o[(r*N+c)*TW +: TW] = TW'(v);
         end
      end
      chg = (o != b);
   endfunction

   function automatic bit model_go(input logic [BW-1:0] b);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (get(b, r, c) == 0) return 1'b0;
            if (c < N - 1 && get(b, r, c) == get(b, r, c + 1) && get(b, r, c) != 15)
               return 1'b0;
            if (r < N - 1 && get(b, r, c) == get(b, r + 1, c) && get(b, r, c) != 15)
               return 1'b0;
         end
      return 1'b1;
   endfunction

   function automatic bit board_ok(input logic [BW-1:0] act, input logic [BW-1:0] req,
                                   input bit allow);
      int diffs;
      diffs = 0;
      for (int i = 0; i < NN; i++)
         if (act[i*TW +: TW] != req[i*TW +: TW]) begin
            diffs++;
            if (req[i*TW +: TW] != '0) return 1'b0;
            if (act[i*TW +: TW] != TW'(1) && act[i*TW +: TW] != TW'(2)) return 1'b0;
         end
      return allow ? (diffs == 1) : (diffs == 0);
   endfunction

   function automatic int nz(input logic [BW-1:0] b);
      int n;
      n = 0;
      for (int i = 0; i < NN; i++)
         if (b[i*TW +: TW] != '0) begin
            if (b[i*TW +: TW] > TW'(2)) n = n + 100;
            n++;
         end
      return n;
   endfunction

   always @(negedge clk) begin
      if (moved) moved_cnt++;
      if (mon_en && !rst && !busy) begin
         checks++;
         if (!board_ok(board, exp_board, exp_spawn)) begin
            errors++;
            $display("FAIL idle_board act=%h req=%h spawn=%0d", board, exp_board, exp_spawn);
         end
         checks++;
         if (int'(score) != exp_score) begin
            errors++;
            $display("FAIL idle_score act=%0d req=%0d", score, exp_score);
         end
         checks++;
         if (game_over != exp_go) begin
            errors++;
            $display("FAIL idle_game_over act=%0d req=%0d", game_over, exp_go);
         end
         checks++;
         if (dir_ready != !exp_go) begin
            errors++;
            $display("FAIL idle_dir_ready act=%0d req=%0d", dir_ready, !exp_go);
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic do_load(input logic [BW-1:0] img);
      wait_idle();
      load_board = img;
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
      exp_board = img;
      exp_score = 0;
      exp_go    = model_go(img);
      exp_spawn = 1'b0;
      mon_en    = 1'b1;
      wait_idle();
   endtask

   task automatic do_move(input logic [3:0] d);
      logic [BW-1:0] nb;
      int inc, lat, m0, s;
      bit chg;
      wait_idle();
      m0 = moved_cnt;
      dir = d;
      dir_valid = 1'b1;
      @(posedge clk); #1;
      dir_valid = 1'b0;
      dir = '0;
      if (exp_go) begin
         chk("blocked_busy", busy, 0);
         return;
      end
      model_move(exp_board, d, nb, inc, chg);
      exp_board = nb;
      s = exp_score + inc;
      exp_score = (s > SMAX) ? SMAX : s;
      exp_spawn = chg;
      if (!chg && model_go(nb)) exp_go = 1'b1;
      lat = 0;
      while (busy && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (busy) chk("move_timeout", 1, 0);
      chk("move_pulses", moved_cnt - m0, chg ? 1 : 0);
      if (!chg) begin
         chk("lat_nospawn", lat, N + 1);
      end else begin
         checks++;
         if (lat < N + 2 || lat > N + NN + 1) begin
            errors++;
            $display("FAIL lat_spawn act=%0d req=%0d..%0d", lat, N + 2, N + NN + 1);
         end
      end
   endtask

   initial begin
      logic [BW-1:0] mb;
      int minc;
      bit mchg;

      // Model pinned against hand-worked lines.
      model_move(mkb('{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0}), DIR_LEFT, mb, minc, mchg);
      chk("pin_1111_board", mb, mkb('{2,2,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      chk("pin_1111_inc", minc, 8);
      model_move(mkb('{1,1,0,2, 0,0,0,0, 0,0,0,0, 0,0,0,0}), DIR_RIGHT, mb, minc, mchg);
      chk("pin_right_board", mb, mkb('{0,0,2,2, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      model_move(mkb('{1,0,0,0, 0,0,0,0, 1,0,0,0, 3,0,0,0}), DIR_UP, mb, minc, mchg);
      chk("pin_up_board", mb, mkb('{2,0,0,0, 3,0,0,0, 0,0,0,0, 0,0,0,0}));
      chk("pin_up_inc", minc, 4);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", busy, 1);
      chk("rst_board", board, 0);
      chk("rst_score", score, 0);
      chk("rst_go", game_over, 0);
      chk("rst_ready", dir_ready, 0);
      wait_idle();
      chk("init_tiles", nz(board), 2);

      do_load(mkb('{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      do_move(DIR_LEFT);
      chk("r032_row0", board[7:0], 8'h22);
      chk("r032_score", score, 8);
      chk("r032_tiles", nz(board), 3);

      do_load(mkb('{1,1,2,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      do_move(DIR_LEFT);
      chk("r033_row0", board[7:0], 8'h22);
      chk("r033_score", score, 4);

      do_load(mkb('{1,2,3,4, 2,3,4,1, 3,4,1,2, 4,1,2,3}));
      chk("r034_go", game_over, 1);
      do_move(DIR_LEFT);
      chk("r034_board", board, 64'h3214_2143_1432_4321);
      chk("r034_score", score, 0);

      do_load(mkb('{15,15,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      do_move(DIR_LEFT);
      chk("r035_row0", board[15:0], 16'h00FF);
      chk("r035_score", score, 0);

      do_load(mkb('{1,1,0,2, 0,0,0,0, 0,0,0,0, 0,0,0,0}));
      do_move(DIR_RIGHT);
      chk("right_row0_hi", board[15:8], 8'h22);
      chk("right_score", score, 4);

      do_load(mkb('{1,0,1,0, 1,2,0,0, 0,2,3,3, 0,0,0,3}));
      do_move(DIR_DOWN);
      do_load(mkb('{1,0,0,0, 0,0,0,0, 1,0,0,0, 3,0,0,0}));
      do_move(DIR_UP);
      chk("up_col0", {board[4*TW +: TW], board[0 +: TW]}, 8'h32);

      do_load(mkb('{0,2,0,2, 0,0,1,0, 0,0,0,0, 3,0,0,0}));
      dir = 4'b0110;
      dir_valid = 1'b1;
      @(posedge clk); #1;
      chk("r037_busy_a", busy, 0);
      @(posedge clk); #1;
      chk("r037_busy_b", busy, 0);
      chk("r037_board", board, mkb('{0,2,0,2, 0,0,1,0, 0,0,0,0, 3,0,0,0}));
      dir_valid = 1'b0;
      dir = '0;

      do_load(mkb('{1,1,0,0, 0,0,2,2, 0,0,0,0, 0,0,0,0}));
      mon_en = 1'b0;
      dir = DIR_LEFT;
      dir_valid = 1'b1;
      @(posedge clk); #1;
      dir_valid = 1'b0;
      dir = '0;
      @(posedge clk); #1;
      chk("r036_mid_score", score, 4);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("r036_score", score, 0);
      chk("r036_go", game_over, 0);
      chk("r036_busy", busy, 1);
      chk("r036_board", board, 0);
      wait_idle();
      chk("r036_tiles", nz(board), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
